ml_layer_engine: RTL and testbench
==================================

ML_LAYER_ENGINE -- requirements
Module: ml_layer_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: usb_clk, reset_n.
REQ-002 Parameters SHALL be: pINPUTCNT, default 4, number of binary inputs; pOUTPUTCNT, default 4, number of neurons; pWEIGHTCNT, default 16, equal to pINPUTCNT*pOUTPUTCNT; pBIASCNT, default 16, total bias bits; pTHRESH, default 1, firing threshold.
REQ-003 Derived constant pBIAS_W = pBIASCNT/pOUTPUTCNT SHALL set the bias bits per neuron, default 4.
REQ-004 Ports SHALL be:
- usb_clk, in, 1: clock.
- reset_n, in, 1: async active-low reset.
- start, in, 1: run request, level-sampled.
- inputs, in, pINPUTCNT: input vector from the register block.
- weights, in, pWEIGHTCNT: binary weights, w[o][i] = weights[o*pINPUTCNT+i].
- bias, in, pBIASCNT: unsigned bias, neuron o = bias[o*pBIAS_W +: pBIAS_W].
- busy, out, 1: high while computing.
- done, out, 1: one-cycle completion pulse.
- outputs, out, pOUTPUTCNT: neuron results, read back by the register block.

Function
REQ-005 The FSM SHALL have states IDLE, RUN, DONE.
REQ-006 In IDLE, start=1 at an edge SHALL capture inputs, weights and bias into internal operand registers, clear o and i to 0, load acc with bias of neuron 0, and enter RUN.
REQ-007 In RUN, each edge SHALL perform acc += (inputs[i] & w[o][i]), one term per cycle, with i incrementing and wrapping at pINPUTCNT-1.
REQ-008 At i = pINPUTCNT-1, the block SHALL write result bit o = ((acc + term) >= pTHRESH) into a shadow register, increment o, and reload acc with bias of neuron o+1.
REQ-009 After the last term of neuron pOUTPUTCNT-1, the FSM SHALL enter DONE, copying the full shadow register into outputs on that same edge.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 busy SHALL be 1 exactly in RUN; a run SHALL take pINPUTCNT*pOUTPUTCNT RUN cycles, i.e. done is high during the 17th cycle after the start-sampling edge with default parameters.
REQ-012 The accumulator SHALL be unsigned, of width clog2(pINPUTCNT + 2^pBIAS_W), and SHALL never wrap.
REQ-013 start SHALL be ignored in RUN and DONE; a start held high SHALL launch the next run on the first IDLE edge.
REQ-014 Changes on inputs, weights or bias after capture SHALL NOT affect the run in progress.
REQ-015 outputs SHALL hold the last committed result and change only on entry to DONE.

Reset
REQ-016 reset_n=0 SHALL, at any time including mid-run, force IDLE and clear busy, done, outputs, the shadow register, acc, o, i and the operand registers to 0.
REQ-017 The first start SHALL be honoured on the first edge after reset_n deasserts.

Structure
REQ-018 The state enum and the accumulator-width function SHALL live in the shared package ml_pkg.
REQ-019 The datapath is flat; no sub-module is required, and the optional term/compare logic, if split out, SHALL be named ml_neuron_acc.

Verification
REQ-020 The bench SHALL cover these directed scenarios with default parameters:
- inputs=0001, weights=FFFF, bias=0000, pTHRESH=1 -> outputs=1111; done one cycle, 17 cycles after start; busy high 16 cycles.
- inputs=0000, weights=FFFF, bias=16'h0123, pTHRESH=2 -> outputs=0011.
- inputs=1111, weights=FFFF, bias=FFFF -> outputs=1111 at pTHRESH=19 and 0000 at pTHRESH=20 (no wrap).
- start held high, inputs changed mid-run -> each run reflects its captured operands; back-to-back runs separated by DONE and IDLE cycles.
- reset_n pulsed low at RUN cycle 8 -> busy=0, done=0, outputs=0 immediately; no done pulse until a new start.
- weights=16'h000F, inputs=1111, bias=0, pTHRESH=1 -> outputs=0001, which checks neuron and weight indexing.

Source files
------------

// File: rtl/ml_pkg.sv
// ml_pkg -- shared definitions for the binary-neuron layer engine.
//   state_t   : engine FSM encoding (IDLE / RUN / DONE).
//   acc_width : accumulator width that holds bias + every possible term
//               without wrapping.
//   idx_width : counter width for an index range of n entries (minimum 1).
package ml_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest sum is (2^bias_w - 1) + n_inputs, which is strictly below
   // n_inputs + 2^bias_w, so this width can never overflow.
   function automatic int acc_width(input int n_inputs, input int bias_w);
      return $clog2(n_inputs + (1 << bias_w));
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ml_neuron_acc.sv
// ml_neuron_acc -- one accumulate step of a binary neuron plus the firing
// compare.
//   i_acc    : running sum before this term
//   i_in_bit : input bit for this term
//   i_w_bit  : weight bit for this term
//   o_sum    : i_acc + (i_in_bit & i_w_bit)
//   o_fire   : o_sum >= pTHRESH (only meaningful on a neuron's last term)
module ml_neuron_acc #(
   parameter int pACC_W  = 5,
   parameter int pTHRESH = 1
) (
   input  logic [pACC_W-1:0] i_acc,
   input  logic              i_in_bit,
   input  logic              i_w_bit,
   output logic [pACC_W-1:0] o_sum,
   output logic              o_fire
);

   assign o_sum  = i_acc + {{(pACC_W-1){1'b0}}, (i_in_bit & i_w_bit)};
   // Compare at 32 bits so thresholds beyond the accumulator range simply
   // never fire instead of being truncated.
   assign o_fire = ({{(32-pACC_W){1'b0}}, o_sum} >= 32'(pTHRESH));

endmodule

// File: rtl/ml_layer_engine.sv
// ml_layer_engine -- serial evaluator for one layer of binary neurons.
// Each neuron o computes bias[o] + sum_i(inputs[i] & w[o][i]) one term per
// clock and fires when the total reaches pTHRESH.
// Ports:
//   usb_clk, reset_n : clock, asynchronous active-low reset
//   start            : level-sampled run request, honoured only in IDLE
//   inputs           : pINPUTCNT input bits
//   weights          : w[o][i] = weights[o*pINPUTCNT+i]
//   bias             : neuron o bias = bias[o*pBIAS_W +: pBIAS_W], unsigned
//   busy             : high exactly while in RUN
//   done             : one-cycle pulse in DONE
//   outputs          : last committed neuron results
// Handshake: start is a level; the edge that samples start=1 in IDLE
// captures all operands, so they may change freely afterwards. The run
// always ends with one DONE cycle and one IDLE cycle before a held start can
// launch the next run. r_state is the FSM state for observation.
module ml_layer_engine
   import ml_pkg::*;
#(
   parameter int pINPUTCNT  = 4,
   parameter int pOUTPUTCNT = 4,
   parameter int pWEIGHTCNT = 16,
   parameter int pBIASCNT   = 16,
   parameter int pTHRESH    = 1
) (
   input  logic                  usb_clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [pINPUTCNT-1:0]  inputs,
   input  logic [pWEIGHTCNT-1:0] weights,
   input  logic [pBIASCNT-1:0]   bias,
   output logic                  busy,
   output logic                  done,
   output logic [pOUTPUTCNT-1:0] outputs
);

   localparam int pBIAS_W = pBIASCNT / pOUTPUTCNT;
   localparam int ACC_W   = acc_width(pINPUTCNT, pBIAS_W);
   localparam int I_W     = idx_width(pINPUTCNT);
   localparam int O_W     = idx_width(pOUTPUTCNT);
   localparam int K_W     = idx_width(pWEIGHTCNT);

   state_t                  r_state;
   logic [pINPUTCNT-1:0]    r_inputs;
   logic [pWEIGHTCNT-1:0]   r_weights;
   logic [pBIASCNT-1:0]     r_bias;
   logic [ACC_W-1:0]        r_acc;
   logic [I_W-1:0]          r_i;
   logic [O_W-1:0]          r_o;
   // Flat weight pointer; always equals r_o*pINPUTCNT + r_i, kept as its own
   // counter to avoid a multiplier in the index path.
   logic [K_W-1:0]          r_k;
   logic [pOUTPUTCNT-1:0]   r_shadow;
   logic [pOUTPUTCNT-1:0]   r_outputs;

   logic [ACC_W-1:0]        w_sum;
   logic                    w_fire;
   logic                    w_last_i;
   logic                    w_last_o;
   logic [O_W-1:0]          w_o_next;
   logic [pBIAS_W-1:0]      w_bias_next;
   logic [pOUTPUTCNT-1:0]   w_shadow_upd;

   ml_neuron_acc #(
      .pACC_W  (ACC_W),
      .pTHRESH (pTHRESH)
   ) u_neuron_acc (
      .i_acc    (r_acc),
      .i_in_bit (r_inputs[r_i]),
      .i_w_bit  (r_weights[r_k]),
      .o_sum    (w_sum),
      .o_fire   (w_fire)
   );

   assign w_last_i = (r_i == I_W'(pINPUTCNT - 1));
   assign w_last_o = (r_o == O_W'(pOUTPUTCNT - 1));
   assign w_o_next = r_o + 1'b1;

   // Bias of the next neuron, selected from the captured operands.
   always_comb begin
      w_bias_next = '0;
      for (int n = 0; n < pOUTPUTCNT; n++) begin
         if (w_o_next == O_W'(n)) begin
            w_bias_next = r_bias[n*pBIAS_W +: pBIAS_W];
         end
      end
   end

   // Shadow including the bit being decided this cycle, so the DONE entry
   // edge can publish a complete result.
   always_comb begin
      w_shadow_upd      = r_shadow;
      w_shadow_upd[r_o] = w_fire;
   end

   always_ff @(posedge usb_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_inputs  <= '0;
         r_weights <= '0;
         r_bias    <= '0;
         r_acc     <= '0;
         r_i       <= '0;
         r_o       <= '0;
         r_k       <= '0;
         r_shadow  <= '0;
         r_outputs <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_inputs  <= inputs;
                  r_weights <= weights;
                  r_bias    <= bias;
                  r_acc     <= ACC_W'(bias[pBIAS_W-1:0]);
                  r_i       <= '0;
                  r_o       <= '0;
                  r_k       <= '0;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_k <= r_k + 1'b1;
               if (w_last_i) begin
                  r_shadow <= w_shadow_upd;
                  r_i      <= '0;
                  r_acc    <= ACC_W'(w_bias_next);
                  if (w_last_o) begin
                     r_o       <= '0;
                     r_outputs <= w_shadow_upd;
                     r_state   <= ST_DONE;
                  end else begin
                     r_o <= w_o_next;
                  end
               end else begin
                  r_acc <= w_sum;
                  r_i   <= r_i + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = (r_state == ST_RUN);
   assign done    = (r_state == ST_DONE);
   assign outputs = r_outputs;

endmodule

// File: tb/tb_ml_layer_engine.sv
// tb_ml_layer_engine -- directed bench for ml_layer_engine. Four instances
// share all inputs and differ only in pTHRESH (1, 2, 19, 20); expected
// outputs are packed as {th20, th19, th2, th1}, one nibble per instance.
module tb_ml_layer_engine;

   logic        usb_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic [3:0]  inputs  = '0;
   logic [15:0] weights = '0;
   logic [15:0] bias    = '0;

   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic [3:0]  outs_th1, outs_th2, outs_th19, outs_th20;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- clock / reset ----------------
   always #5 usb_clk = ~usb_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   ml_layer_engine #(.pTHRESH(1)) u_th1 (
      .usb_clk(usb_clk), .reset_n(reset_n), .start(start), .inputs(inputs),
      .weights(weights), .bias(bias), .busy(busy_v[0]), .done(done_v[0]),
      .outputs(outs_th1));
   ml_layer_engine #(.pTHRESH(2)) u_th2 (
      .usb_clk(usb_clk), .reset_n(reset_n), .start(start), .inputs(inputs),
      .weights(weights), .bias(bias), .busy(busy_v[1]), .done(done_v[1]),
      .outputs(outs_th2));
   ml_layer_engine #(.pTHRESH(19)) u_th19 (
      .usb_clk(usb_clk), .reset_n(reset_n), .start(start), .inputs(inputs),
      .weights(weights), .bias(bias), .busy(busy_v[2]), .done(done_v[2]),
      .outputs(outs_th19));
   ml_layer_engine #(.pTHRESH(20)) u_th20 (
      .usb_clk(usb_clk), .reset_n(reset_n), .start(start), .inputs(inputs),
      .weights(weights), .bias(bias), .busy(busy_v[3]), .done(done_v[3]),
      .outputs(outs_th20));

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [15:0] exp);
      chk({tag, "/out_th1"},  32'(outs_th1),  32'(exp[3:0]));
      chk({tag, "/out_th2"},  32'(outs_th2),  32'(exp[7:4]));
      chk({tag, "/out_th19"}, 32'(outs_th19), 32'(exp[11:8]));
      chk({tag, "/out_th20"}, 32'(outs_th20), 32'(exp[15:12]));
   endtask

   // Counts negedges until done is seen (bounded). cyc stays 0 on timeout,
   // which the caller's cycle check then reports.
   task automatic wait_done(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge usb_clk);
         if (busy_v[0]) bcyc++;
         if (done_v[0]) begin
            cyc = k;
            break;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic [3:0] inp, input logic [15:0] w, input logic [15:0] b);
      inputs  = inp;
      weights = w;
      bias    = b;
   endtask

   task automatic run(input string tag, input logic [3:0] inp, input logic [15:0] w,
                      input logic [15:0] b, input logic [15:0] exp);
      int cyc, bcyc;
      @(negedge usb_clk);
      drive(inp, w, b);
      start = 1'b1;
      @(posedge usb_clk);
      #1 start = 1'b0;
      wait_done(cyc, bcyc);
      chk({tag, "/done_cycle"}, 32'(cyc), 32'd17);
      chk({tag, "/busy_cycles"}, 32'(bcyc), 32'd16);
      chk({tag, "/done_all"}, 32'(done_v), 32'hF);
      chk_outs(tag, exp);
      @(negedge usb_clk);
      chk({tag, "/done_pulse_end"}, 32'(done_v), 32'h0);
      chk({tag, "/busy_after"}, 32'(busy_v), 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc, bcyc, dcount, bcount;

      repeat (3) @(negedge usb_clk);
      chk("reset/busy", 32'(busy_v), 32'h0);
      chk("reset/done", 32'(done_v), 32'h0);
      chk_outs("reset", 16'h0000);
      reset_n = 1'b1;

      // Single input bit on, all weights: every neuron sums to exactly 1.
      run("one_input",  4'b0001, 16'hFFFF, 16'h0000, 16'h000F);
      // Bias only: neuron sums 3,2,1,0.
      run("bias_only",  4'b0000, 16'hFFFF, 16'h0123, 16'h0037);
      // Maximum sum 15+4=19 must not wrap.
      run("max_sum",    4'b1111, 16'hFFFF, 16'hFFFF, 16'h0FFF);
      // Only neuron 0 weights set: neuron 0 sums to 4, others 0.
      run("indexing",   4'b1111, 16'h000F, 16'h0000, 16'h0011);

      // Start held high; operands change mid-run.
      @(negedge usb_clk);
      drive(4'b1111, 16'hFFFF, 16'h0000);          // run A: all sums 4
      start = 1'b1;
      @(posedge usb_clk);
      #1;
      repeat (5) @(negedge usb_clk);
      drive(4'b0000, 16'hFFFF, 16'h0000);          // run B: all sums 0
      wait_done(cyc, bcyc);
      chk("held_a/done_cycle", 32'(cyc), 32'd12);
      chk_outs("held_a", 16'h00FF);
      @(negedge usb_clk);
      chk("held_gap/done", 32'(done_v), 32'h0);
      chk("held_gap/busy", 32'(busy_v), 32'h0);
      @(negedge usb_clk);
      chk("held_b/busy_start", 32'(busy_v), 32'hF);
      repeat (3) @(negedge usb_clk);
      drive(4'b0001, 16'h00F0, 16'h0000);          // run C: neuron 1 sums 1
      wait_done(cyc, bcyc);
      chk("held_b/done_cycle", 32'(cyc), 32'd13);
      chk_outs("held_b", 16'h0000);
      @(negedge usb_clk);
      @(posedge usb_clk);
      #1 start = 1'b0;
      wait_done(cyc, bcyc);
      chk("held_c/done_cycle", 32'(cyc), 32'd17);
      chk_outs("held_c", 16'h0002);
      repeat (3) @(negedge usb_clk);
      chk("held_c/idle_busy", 32'(busy_v), 32'h0);

      // Load a known nonzero result, then reset at RUN cycle 8.
      run("pre_reset",  4'b1111, 16'hFFFF, 16'hFFFF, 16'h0FFF);
      @(negedge usb_clk);
      start = 1'b1;
      @(posedge usb_clk);
      #1 start = 1'b0;
      repeat (8) @(negedge usb_clk);
      reset_n = 1'b0;
      #1;
      chk("midrst/busy", 32'(busy_v), 32'h0);
      chk("midrst/done", 32'(done_v), 32'h0);
      chk_outs("midrst", 16'h0000);
      @(negedge usb_clk);
      reset_n = 1'b1;
      dcount = 0;
      bcount = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge usb_clk);
         if (done_v != 4'h0) dcount++;
         if (busy_v != 4'h0) bcount++;
      end
      chk("midrst/no_done", 32'(dcount), 32'd0);
      chk("midrst/no_busy", 32'(bcount), 32'd0);
      chk_outs("midrst_hold", 16'h0000);

      // Start present at reset release is taken on the first edge.
      @(negedge usb_clk);
      reset_n = 1'b0;
      drive(4'b1111, 16'h000F, 16'h0000);
      @(negedge usb_clk);
      reset_n = 1'b1;
      start   = 1'b1;
      @(posedge usb_clk);
      #1 start = 1'b0;
      wait_done(cyc, bcyc);
      chk("first_start/done_cycle", 32'(cyc), 32'd17);
      chk("first_start/busy_cycles", 32'(bcyc), 32'd16);
      chk_outs("first_start", 16'h0011);

      repeat (2) @(negedge usb_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
